// File: rtl/lpc_host_ng.sv
// LPC host master: turns single-byte valid/ready requests into LPC I/O or
// memory read/write cycles, with sync-wait timeouts, abort sequencing and
// a stretched LRESET# after reset.
module lpc_host_ng #(
    parameter int MEM_ADDR_W     = 32,
    parameter int SHORT_WAIT_MAX = 8,
    parameter int LONG_WAIT_MAX  = 1024,
    parameter int RESET_CYCLES   = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic        req_mem_i,
    input  logic [31:0] req_addr_i,
    input  logic [7:0]  req_wdata_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_rdata_o,
    output logic [1:0]  rsp_status_o,
    output logic        busy_o,
    output logic [4:0]  state_o,
    input  logic [3:0]  lad_i,
    output logic [3:0]  lad_o,
    output logic        lad_oe_o,
    output logic        lframe_n_o,
    output logic        lreset_n_o
);

    localparam int MAX_AB = (SHORT_WAIT_MAX > LONG_WAIT_MAX) ? SHORT_WAIT_MAX : LONG_WAIT_MAX;
    localparam int MAXC   = (MAX_AB > RESET_CYCLES) ? MAX_AB : RESET_CYCLES;
    localparam int CNT_W  = $clog2(MAXC + 2) + 1;
    localparam bit MEM32  = (MEM_ADDR_W == 32);

    localparam logic [CNT_W-1:0] SHORT_LIM = CNT_W'(SHORT_WAIT_MAX);
    localparam logic [CNT_W-1:0] LONG_LIM  = CNT_W'(LONG_WAIT_MAX);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    typedef enum logic [4:0] {
        S_RST       = 5'd0,
        S_IDLE      = 5'd1,
        S_START     = 5'd2,
        S_CYCTYPE   = 5'd3,
        S_ADDR      = 5'd4,
        S_WDATA     = 5'd5,
        S_HTAR1     = 5'd6,
        S_HTAR2     = 5'd7,
        S_SYNC      = 5'd8,
        S_RDATA     = 5'd9,
        S_PTAR      = 5'd10,
        S_ABORT     = 5'd11,
        S_ABORT_END = 5'd12,
        S_RESP      = 5'd13
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d, wait_n, addr_last;
    logic             wlong, wlong_d;
    logic [1:0]       status_q, status_d;
    logic [31:0]      addr_q;
    logic [7:0]       wdata_q, rbuf, rdata_q;
    logic             wr_q, mem_q;
    logic [2:0]       nib_idx;

    // Address is stored MSB-aligned so nibble 7 is always the first one driven.
    assign addr_last   = (mem_q && MEM32) ? CNT_W'(7) : CNT_W'(3);
    assign nib_idx     = 3'd7 - cnt[2:0];

    assign busy_o       = (state != S_IDLE);
    assign lreset_n_o   = (state != S_RST);
    assign state_o      = state;
    assign rsp_rdata_o  = rdata_q;
    assign rsp_status_o = status_q;

    // State, counters, request capture and read-data registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_RST;
            cnt      <= '0;
            wlong    <= 1'b0;
            status_q <= '0;
            rdata_q  <= '0;
            rbuf     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            mem_q    <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            wlong    <= wlong_d;
            status_q <= status_d;
            if (state == S_IDLE && req_valid_i) begin
                wr_q    <= req_write_i;
                mem_q   <= req_mem_i;
                wdata_q <= req_wdata_i;
                if (req_mem_i && MEM32) addr_q <= req_addr_i;
                else                    addr_q <= {req_addr_i[15:0], 16'h0000};
            end
            if (state == S_RDATA) begin
                if (cnt[0]) rbuf[7:4] <= lad_i;
                else        rbuf[3:0] <= lad_i;
            end
            // Publish read data on the last PTAR cycle so it is stable during RESP.
            if (state == S_PTAR && cnt[0] && !wr_q) rdata_q <= rbuf;
        end
    end

    // Next-state, counter update and LPC/request output decode.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt + ONE;
        wlong_d     = wlong;
        status_d    = status_q;
        wait_n      = ONE;
        lad_o       = 4'hF;
        lad_oe_o    = 1'b0;
        lframe_n_o  = 1'b1;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state)
            S_RST: if (cnt == RST_LAST) state_d = S_IDLE;
            S_IDLE: begin
                req_ready_o = 1'b1;
                cnt_d       = '0;
                if (req_valid_i) state_d = S_START;
            end
            S_START: begin
                lframe_n_o = 1'b0;
                lad_oe_o   = 1'b1;
                lad_o      = 4'h0;
                state_d    = S_CYCTYPE;
            end
            S_CYCTYPE: begin
                lad_oe_o = 1'b1;
                lad_o    = {1'b0, mem_q, wr_q, 1'b0};
                state_d  = S_ADDR;
            end
            S_ADDR: begin
                lad_oe_o = 1'b1;
                lad_o    = addr_q[{nib_idx, 2'b00} +: 4];
                if (cnt == addr_last) state_d = wr_q ? S_WDATA : S_HTAR1;
            end
            S_WDATA: begin
                lad_oe_o = 1'b1;
                lad_o    = cnt[0] ? wdata_q[7:4] : wdata_q[3:0];
                if (cnt[0]) state_d = S_HTAR1;
            end
            S_HTAR1: begin
                lad_oe_o = 1'b1;
                state_d  = S_HTAR2;
            end
            S_HTAR2: state_d = S_SYNC;
            S_SYNC: begin
                // Wait count restarts on SYNC entry (cnt==0) or when the wait type flips.
                case (lad_i)
                    4'b0000: begin
                        status_d = 2'b00;
                        state_d  = wr_q ? S_PTAR : S_RDATA;
                    end
                    4'b1010: begin
                        status_d = 2'b01;
                        state_d  = wr_q ? S_PTAR : S_RDATA;
                    end
                    4'b0101: begin
                        wait_n  = (wlong || cnt == '0) ? ONE : cnt + ONE;
                        wlong_d = 1'b0;
                        cnt_d   = wait_n;
                        if (wait_n > SHORT_LIM) begin
                            status_d = 2'b10;
                            state_d  = S_ABORT;
                        end
                    end
                    4'b0110: begin
                        wait_n  = (!wlong || cnt == '0) ? ONE : cnt + ONE;
                        wlong_d = 1'b1;
                        cnt_d   = wait_n;
                        if (wait_n > LONG_LIM) begin
                            status_d = 2'b10;
                            state_d  = S_ABORT;
                        end
                    end
                    default: begin
                        status_d = 2'b11;
                        state_d  = S_ABORT;
                    end
                endcase
            end
            S_RDATA: if (cnt[0]) state_d = S_PTAR;
            S_PTAR:  if (cnt[0]) state_d = S_RESP;
            S_ABORT: begin
                lframe_n_o = 1'b0;
                lad_oe_o   = 1'b1;
                if (cnt == CNT_W'(3)) state_d = S_ABORT_END;
            end
            S_ABORT_END: state_d = S_RESP;
            S_RESP: begin
                rsp_valid_o = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_RST;
        endcase
        if (state_d != state) cnt_d = '0;
    end

endmodule

// File: tb/tb_lpc_host_ng.sv
// Directed bench for lpc_host_ng: a scripted peripheral answers on lad_i
// cycle by cycle and every response and LAD nibble is compared against
// hand-derived values.
module tb_lpc_host_ng;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i, req_ready_o, req_write_i, req_mem_i;
    logic [31:0] req_addr_i;
    logic [7:0]  req_wdata_i;
    logic        rsp_valid_o;
    logic [7:0]  rsp_rdata_o;
    logic [1:0]  rsp_status_o;
    logic        busy_o;
    logic [4:0]  state_o;
    logic [3:0]  lad_i, lad_o;
    logic        lad_oe_o, lframe_n_o, lreset_n_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Peripheral script and observation, indexed by cycle after the accept edge.
    logic [3:0] periph  [0:63];
    logic [3:0] obs_lad [0:63];
    logic       obs_oe  [0:63];
    logic       obs_fr  [0:63];
    int         rsp_lat;
    logic [1:0] rsp_st;
    logic [7:0] rsp_rd;

    lpc_host_ng #(
        .MEM_ADDR_W    (32),
        .SHORT_WAIT_MAX(8),
        .LONG_WAIT_MAX (16),
        .RESET_CYCLES  (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_mem_i   (req_mem_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_status_o(rsp_status_o),
        .busy_o      (busy_o),
        .state_o     (state_o),
        .lad_i       (lad_i),
        .lad_o       (lad_o),
        .lad_oe_o    (lad_oe_o),
        .lframe_n_o  (lframe_n_o),
        .lreset_n_o  (lreset_n_o)
    );

    always #5 clk = ~clk;

    task automatic clear_periph();
        for (int i = 0; i < 64; i++) periph[i] = 4'hF;
    endtask

    task automatic do_req(input logic wr, input logic mem, input logic [31:0] addr,
                          input logic [7:0] wd, input int maxc);
        @(posedge clk); #1;
        req_valid_i = 1'b1; req_write_i = wr; req_mem_i = mem;
        req_addr_i = addr; req_wdata_i = wd; lad_i = 4'hF;
        n_checks++;
        if (req_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL req_ready before request: got %b expected 1", req_ready_o);
        end
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        rsp_lat = -1;
        for (int k = 1; k <= maxc; k++) begin
            lad_i = periph[k];
            @(negedge clk);
            obs_lad[k] = lad_o; obs_oe[k] = lad_oe_o; obs_fr[k] = lframe_n_o;
            if (rsp_valid_o === 1'b1) begin
                rsp_lat = k - 1; rsp_st = rsp_status_o; rsp_rd = rsp_rdata_o;
                break;
            end
            @(posedge clk); #1;
        end
        lad_i = 4'hF;
        n_checks++;
        if (rsp_lat < 0) begin
            n_fail++; $display("FAIL rsp_timeout: got no rsp_valid expected pulse within %0d cycles", maxc);
        end else begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL rsp_pulse_end: got valid=%b ready=%b expected valid=0 ready=1",
                         rsp_valid_o, req_ready_o);
            end
        end
    endtask

    task automatic test_reset();
        int low;
        rst_i = 1'b1; req_valid_i = 1'b0; req_write_i = 1'b0; req_mem_i = 1'b0;
        req_addr_i = '0; req_wdata_i = '0; lad_i = 4'hF;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if ({lreset_n_o, lframe_n_o, lad_oe_o, lad_o, req_ready_o, rsp_valid_o, busy_o} !== 10'b0_1_0_1111_0_0_1
            || rsp_rdata_o !== 8'h00 || rsp_status_o !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_values: got lrst=%b fr=%b oe=%b lad=%h rdy=%b rv=%b busy=%b rd=%h st=%b expected 0 1 0 f 0 0 1 00 00",
                     lreset_n_o, lframe_n_o, lad_oe_o, lad_o, req_ready_o, rsp_valid_o, busy_o, rsp_rdata_o, rsp_status_o);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_i = 1'b0;
        low = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (lreset_n_o === 1'b0) low++;
            else break;
        end
        n_checks++;
        if (low != 16) begin
            n_fail++; $display("FAIL lreset_stretch: got %0d cycles expected 16", low);
        end
        n_checks++;
        if (req_ready_o !== 1'b1 || lframe_n_o !== 1'b1 || lad_oe_o !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got rdy=%b fr=%b oe=%b expected 1 1 0", req_ready_o, lframe_n_o, lad_oe_o);
        end
    endtask

    task automatic test_io_write();
        logic [3:0] exp [0:8];
        exp = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h8, 4'h0, 4'h5, 4'hA, 4'hF};
        clear_periph();
        periph[11] = 4'h0;
        do_req(1'b1, 1'b0, 32'h0000_0080, 8'hA5, 60);
        for (int k = 1; k <= 9; k++) begin
            n_checks++;
            if (obs_lad[k] !== exp[k-1] || obs_oe[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL io_write lad[%0d]: got %h oe=%b expected %h oe=1", k, obs_lad[k], obs_oe[k], exp[k-1]);
            end
        end
        n_checks++;
        if (obs_fr[1] !== 1'b0 || obs_fr[2] !== 1'b1 || obs_oe[10] !== 1'b0) begin
            n_fail++;
            $display("FAIL io_write framing: got fr1=%b fr2=%b oe10=%b expected 0 1 0", obs_fr[1], obs_fr[2], obs_oe[10]);
        end
        n_checks++;
        if (rsp_lat != 13 || rsp_st !== 2'b00) begin
            n_fail++; $display("FAIL io_write rsp: got lat=%0d st=%b expected 13 00", rsp_lat, rsp_st);
        end
    endtask

    task automatic test_mem_read();
        logic [3:0] exp [0:8];
        exp = '{4'h4, 4'hF, 4'hF, 4'hC, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
        clear_periph();
        periph[13] = 4'h5; periph[14] = 4'h5; periph[15] = 4'h5;
        periph[16] = 4'h0; periph[17] = 4'h3; periph[18] = 4'hC;
        do_req(1'b0, 1'b1, 32'hFFC0_1234, 8'h00, 60);
        for (int k = 2; k <= 10; k++) begin
            n_checks++;
            if (obs_lad[k] !== exp[k-2]) begin
                n_fail++; $display("FAIL mem_read lad[%0d]: got %h expected %h", k, obs_lad[k], exp[k-2]);
            end
        end
        n_checks++;
        if (rsp_lat != 20 || rsp_st !== 2'b00 || rsp_rd !== 8'hC3) begin
            n_fail++;
            $display("FAIL mem_read rsp: got lat=%0d st=%b rd=%h expected 20 00 c3", rsp_lat, rsp_st, rsp_rd);
        end
    endtask

    task automatic test_long_wait();
        clear_periph();
        for (int k = 9; k < 64; k++) periph[k] = 4'h6;
        do_req(1'b0, 1'b0, 32'h0000_0060, 8'h00, 60);
        for (int k = 26; k <= 29; k++) begin
            n_checks++;
            if (obs_fr[k] !== 1'b0 || obs_lad[k] !== 4'hF || obs_oe[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL long_wait abort[%0d]: got fr=%b lad=%h oe=%b expected 0 f 1", k, obs_fr[k], obs_lad[k], obs_oe[k]);
            end
        end
        n_checks++;
        if (obs_fr[25] !== 1'b1 || obs_fr[30] !== 1'b1 || obs_oe[30] !== 1'b0) begin
            n_fail++;
            $display("FAIL long_wait edges: got fr25=%b fr30=%b oe30=%b expected 1 1 0", obs_fr[25], obs_fr[30], obs_oe[30]);
        end
        n_checks++;
        if (rsp_lat != 30 || rsp_st !== 2'b10 || rsp_rd !== 8'hC3) begin
            n_fail++;
            $display("FAIL long_wait rsp: got lat=%0d st=%b rd=%h expected 30 10 c3", rsp_lat, rsp_st, rsp_rd);
        end
    endtask

    task automatic test_no_periph();
        clear_periph();
        do_req(1'b0, 1'b0, 32'h0000_0070, 8'h00, 60);
        n_checks++;
        if (obs_fr[10] !== 1'b0 || obs_fr[13] !== 1'b0 || obs_fr[14] !== 1'b1) begin
            n_fail++;
            $display("FAIL no_periph abort: got fr10=%b fr13=%b fr14=%b expected 0 0 1", obs_fr[10], obs_fr[13], obs_fr[14]);
        end
        n_checks++;
        if (rsp_lat != 14 || rsp_st !== 2'b11 || rsp_rd !== 8'hC3) begin
            n_fail++;
            $display("FAIL no_periph rsp: got lat=%0d st=%b rd=%h expected 14 11 c3", rsp_lat, rsp_st, rsp_rd);
        end
    endtask

    task automatic test_sync_error();
        clear_periph();
        periph[9] = 4'hA; periph[10] = 4'h7; periph[11] = 4'h5;
        do_req(1'b0, 1'b0, 32'h0000_0300, 8'h00, 60);
        n_checks++;
        if (rsp_lat != 13 || rsp_st !== 2'b01 || rsp_rd !== 8'h57) begin
            n_fail++;
            $display("FAIL sync_error rsp: got lat=%0d st=%b rd=%h expected 13 01 57", rsp_lat, rsp_st, rsp_rd);
        end
    endtask

    task automatic test_short_abort();
        clear_periph();
        for (int k = 9; k <= 17; k++) periph[k] = 4'h5;
        do_req(1'b0, 1'b0, 32'h0000_0310, 8'h00, 60);
        n_checks++;
        if (rsp_lat != 22 || rsp_st !== 2'b10 || rsp_rd !== 8'h57 || obs_fr[18] !== 1'b0) begin
            n_fail++;
            $display("FAIL short_abort rsp: got lat=%0d st=%b rd=%h fr18=%b expected 22 10 57 0",
                     rsp_lat, rsp_st, rsp_rd, obs_fr[18]);
        end
    endtask

    task automatic test_wait_switch();
        clear_periph();
        for (int k = 9; k <= 16; k++) periph[k] = 4'h5;
        periph[17] = 4'h6;
        for (int k = 18; k <= 25; k++) periph[k] = 4'h5;
        periph[26] = 4'h0; periph[27] = 4'h1; periph[28] = 4'h2;
        do_req(1'b0, 1'b0, 32'h0000_0320, 8'h00, 60);
        n_checks++;
        if (rsp_lat != 30 || rsp_st !== 2'b00 || rsp_rd !== 8'h21) begin
            n_fail++;
            $display("FAIL wait_switch rsp: got lat=%0d st=%b rd=%h expected 30 00 21", rsp_lat, rsp_st, rsp_rd);
        end
    endtask

    task automatic test_reset_mid_addr();
        int  low;
        logic seen;
        @(posedge clk); #1;
        req_valid_i = 1'b1; req_write_i = 1'b1; req_mem_i = 1'b0;
        req_addr_i = 32'h0000_1234; req_wdata_i = 8'h3C; lad_i = 4'hF;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (lad_oe_o !== 1'b1 || lframe_n_o !== 1'b1) begin
            n_fail++; $display("FAIL mid_addr phase: got oe=%b fr=%b expected 1 1", lad_oe_o, lframe_n_o);
        end
        rst_i = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (lad_oe_o !== 1'b0 || lframe_n_o !== 1'b1 || lreset_n_o !== 1'b0 || rsp_valid_o !== 1'b0
            || rsp_rdata_o !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_addr reset: got oe=%b fr=%b lrst=%b rv=%b rd=%h expected 0 1 0 0 00",
                     lad_oe_o, lframe_n_o, lreset_n_o, rsp_valid_o, rsp_rdata_o);
        end
        @(posedge clk); #1;
        rst_i = 1'b0;
        low  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid_o === 1'b1) seen = 1'b1;
            if (lreset_n_o === 1'b0) low++;
        end
        n_checks++;
        if (seen !== 1'b0 || low != 16) begin
            n_fail++; $display("FAIL mid_addr aftermath: got rsp_seen=%b lrst_low=%0d expected 0 16", seen, low);
        end
    endtask

    task automatic test_recover();
        clear_periph();
        periph[11] = 4'h0;
        do_req(1'b1, 1'b0, 32'h0000_0081, 8'h5A, 60);
        n_checks++;
        if (rsp_lat != 13 || rsp_st !== 2'b00 || obs_lad[7] !== 4'hA || obs_lad[8] !== 4'h5) begin
            n_fail++;
            $display("FAIL recover rsp: got lat=%0d st=%b d0=%h d1=%h expected 13 00 a 5",
                     rsp_lat, rsp_st, obs_lad[7], obs_lad[8]);
        end
    endtask

    initial begin
        test_reset();
        test_io_write();
        test_mem_read();
        test_long_wait();
        test_no_periph();
        test_sync_error();
        test_short_abort();
        test_wait_switch();
        test_reset_mid_addr();
        test_recover();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
